wb_arbiter: RTL and testbench

- Write-back arbiter sitting between the execute-side result producers and the GP register file write port (we / addr_c / data_in).
- Merges two result streams into one registered write per cycle:
  - single-cycle ALU results;
  - long-latency results (multiply/divide, loads).
- Buffers long-latency results in a small FIFO.
- Keeps a pending-destination scoreboard so decode can stall on registers with outstanding long-latency writes.

---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_fifo.sv | 50 +++++
 rtl/wb_arbiter.sv | 107 ++++++++++
 tb/tb_wb_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, register-zero constant and write-back entry type
package wb_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam logic [DEF_REG_AW-1:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic [DEF_REG_AW-1:0] rd;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO buffering long-latency write-back entries
// Ports: clk, reset (async, active-high); i_push/i_data write side,
//        i_pop/o_data read side (o_data is the current head);
//        o_full, o_empty, o_count status from the registered count.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and long-latency results onto the register file write port
// Ports: clk, reset (async, active-high)
//        i_alu_valid/i_alu_rd/i_alu_data   single-cycle results, always accepted
//        i_lat_valid/o_lat_ready/i_lat_rd/i_lat_data  buffered long-latency results
//        i_issue_valid/i_issue_rd          marks a destination pending
//        i_query_a/b, o_busy_a/b           pending lookup for decode
//        o_rf_we/o_rf_waddr/o_rf_wdata     registered write port
//        o_fwd_a/b_valid, o_fwd_a/b_data   only when WB_FWD_EN is defined
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_AW     = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_alu_valid,
    input  logic [REG_AW-1:0] i_alu_rd,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic              i_lat_valid,
    output logic              o_lat_ready,
    input  logic [REG_AW-1:0] i_lat_rd,
    input  logic [DATA_W-1:0] i_lat_data,
    input  logic              i_issue_valid,
    input  logic [REG_AW-1:0] i_issue_rd,
    input  logic [REG_AW-1:0] i_query_a,
    input  logic [REG_AW-1:0] i_query_b,
    output logic              o_busy_a,
    output logic              o_busy_b,
`ifdef WB_FWD_EN
    output logic              o_fwd_a_valid,
    output logic [DATA_W-1:0] o_fwd_a_data,
    output logic              o_fwd_b_valid,
    output logic [DATA_W-1:0] o_fwd_b_data,
`endif
    output logic              o_rf_we,
    output logic [REG_AW-1:0] o_rf_waddr,
    output logic [DATA_W-1:0] o_rf_wdata
);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int NREG = 1 << REG_AW;

    logic                     w_push, w_pop, w_full, w_empty, w_win, w_unused;
    logic [CW-1:0]            w_count;
    logic [REG_AW+DATA_W-1:0] w_head;
    logic [REG_AW-1:0]        w_head_rd, w_win_rd;
    logic [DATA_W-1:0]        w_head_data, w_win_data;
    logic [NREG-1:0]          w_set, w_clr, r_pending;
    logic                     r_rf_we;
    logic [REG_AW-1:0]        r_rf_waddr;
    logic [DATA_W-1:0]        r_rf_wdata;

    wb_fifo #(.DEPTH(FIFO_DEPTH), .W(REG_AW + DATA_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({i_lat_rd, i_lat_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // ready comes from the registered count only, so a same-cycle pop never raises it
    assign o_lat_ready = (w_count != CW'(FIFO_DEPTH));
    assign w_unused    = w_full;
    assign w_push      = i_lat_valid & o_lat_ready;
    assign w_pop       = ~i_alu_valid & ~w_empty;
    assign {w_head_rd, w_head_data} = w_head;
    assign w_win       = i_alu_valid | ~w_empty;
    assign w_win_rd    = i_alu_valid ? i_alu_rd : w_head_rd;
    assign w_win_data  = i_alu_valid ? i_alu_data : w_head_data;
    assign w_set       = (i_issue_valid && i_issue_rd != REG_ZERO) ? NREG'(1) << i_issue_rd : '0;
    assign w_clr       = w_pop ? NREG'(1) << w_head_rd : '0;

    // a winner targeting r0 is still consumed but never writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_pending  <= '0;
        end else begin
            r_rf_we <= w_win & (w_win_rd != REG_ZERO);
            if (w_win) begin
                r_rf_waddr <= w_win_rd;
                r_rf_wdata <= w_win_data;
            end
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    assign o_rf_we    = r_rf_we;
    assign o_rf_waddr = r_rf_waddr;
    assign o_rf_wdata = r_rf_wdata;
    assign o_busy_a   = r_pending[i_query_a] & (i_query_a != REG_ZERO);
    assign o_busy_b   = r_pending[i_query_b] & (i_query_b != REG_ZERO);

`ifdef WB_FWD_EN
    assign o_fwd_a_valid = r_rf_we & (r_rf_waddr == i_query_a) & (i_query_a != REG_ZERO);
    assign o_fwd_b_valid = r_rf_we & (r_rf_waddr == i_query_b) & (i_query_b != REG_ZERO);
    assign o_fwd_a_data  = r_rf_wdata;
    assign o_fwd_b_data  = r_rf_wdata;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a queue-based model
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, lat_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]  alu_rd = '0, lat_rd = '0, issue_rd = '0, query_a = '0, query_b = '0;
    logic [31:0] alu_data = '0, lat_data = '0;
    logic        lat_ready, busy_a, busy_b, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_FWD_EN
    logic        fwd_a_valid, fwd_b_valid;
    logic [31:0] fwd_a_data, fwd_b_data;
`endif

    int n_checks = 0;
    int n_fail = 0;

    wb_entry_t   m_q[$];
    bit          m_pend[32];
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(32), .REG_AW(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_alu_valid   (alu_valid),
        .i_alu_rd      (alu_rd),
        .i_alu_data    (alu_data),
        .i_lat_valid   (lat_valid),
        .o_lat_ready   (lat_ready),
        .i_lat_rd      (lat_rd),
        .i_lat_data    (lat_data),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .i_query_a     (query_a),
        .i_query_b     (query_b),
        .o_busy_a      (busy_a),
        .o_busy_b      (busy_b),
`ifdef WB_FWD_EN
        .o_fwd_a_valid (fwd_a_valid),
        .o_fwd_a_data  (fwd_a_data),
        .o_fwd_b_valid (fwd_b_valid),
        .o_fwd_b_data  (fwd_b_data),
`endif
        .o_rf_we       (rf_we),
        .o_rf_waddr    (rf_waddr),
        .o_rf_wdata    (rf_wdata)
    );

    task automatic model_clear();
        m_q.delete();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_we = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // advance one clock; the model applies the write-back rules to the inputs seen at the edge
    task automatic tick();
        wb_entry_t e;
        bit rdy;
        rdy = (m_q.size() != DEPTH);
        @(posedge clk);
        if (alu_valid) begin
            m_we = (alu_rd != 0);
            m_addr = alu_rd;
            m_data = alu_data;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_we = (e.rd != 0);
            m_addr = e.rd;
            m_data = e.data;
            m_pend[e.rd] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (lat_valid && rdy) begin
            e.rd = lat_rd;
            e.data = lat_data;
            m_q.push_back(e);
        end
        if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        lat_valid = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic test_reset();
        model_clear();
        #12;
        n_checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rf: we=%b addr=%0d data=%h required 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (lat_ready !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: ready=%b busy=%b%b required 1/00", lat_ready, busy_a, busy_b);
        end
        tick();
    endtask

    task automatic test_alu();
        alu_valid = 1'b1;
        alu_rd = 5'd5;
        alu_data = 32'hDEADBEEF;
        tick();
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL alu_write: we=%b addr=%0d data=%h required 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        alu_valid = 1'b0;
        tick();
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_idle: we=%b required 0", rf_we);
        end
    endtask

    task automatic test_priority();
        alu_valid = 1'b1;
        alu_rd = 5'd3;
        alu_data = 32'h33;
        issue_valid = 1'b1;
        issue_rd = 5'd7;
        lat_valid = 1'b1;
        lat_rd = 5'd7;
        lat_data = 32'h11;
        query_a = 5'd7;
        for (int k = 0; k < 3; k++) begin
            tick();
            issue_valid = 1'b0;
            lat_valid = 1'b0;
            #1;
            n_checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || busy_a !== 1'b1) begin
                n_fail++;
                $display("FAIL prio_alu%0d: we=%b addr=%0d busy_a=%b required 1/3/1", k, rf_we, rf_waddr, busy_a);
            end
        end
        alu_valid = 1'b0;
        #1;
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_busy_clearing: busy_a=%b required 1", busy_a);
        end
        tick();
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h11 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_fifo: we=%b addr=%0d data=%h busy_a=%b required 1/7/11/0", rf_we, rf_waddr, rf_wdata, busy_a);
        end
        tick();
    endtask

    task automatic test_fill();
        int acc = 0;
        alu_valid = 1'b1;
        alu_rd = 5'd1;
        alu_data = 32'h1;
        lat_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            lat_rd = 5'(10 + acc);
            lat_data = acc;
            #1;
            n_checks++;
            if (lat_ready !== (acc < DEPTH)) begin
                n_fail++;
                $display("FAIL fill_ready%0d: ready=%b required %b", k, lat_ready, acc < DEPTH);
            end
            if (lat_ready) acc++;
            tick();
        end
        alu_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            lat_valid = (acc < 5);
            lat_rd = 5'(10 + acc);
            lat_data = acc;
            #1;
            n_checks++;
            if (lat_valid && lat_ready !== (c > 0)) begin
                n_fail++;
                $display("FAIL drain_ready%0d: ready=%b required %b", c, lat_ready, c > 0);
            end
            if (lat_valid && lat_ready) acc++;
            tick();
            n_checks++;
            if (c < 5 && (rf_we !== 1'b1 || rf_waddr !== 5'(10 + c) || rf_wdata !== c)) begin
                n_fail++;
                $display("FAIL drain_order%0d: we=%b addr=%0d data=%h required 1/%0d/%h", c, rf_we, rf_waddr, rf_wdata, 10 + c, c);
            end else if (c == 5 && rf_we !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_end: we=%b required 0", rf_we);
            end
        end
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1;
        issue_rd = 5'd9;
        query_a = 5'd9;
        query_b = 5'd8;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1;
        alu_rd = 5'd2;
        lat_valid = 1'b1;
        lat_rd = 5'd9;
        lat_data = 32'h99;
        tick();
        lat_valid = 1'b0;
        alu_valid = 1'b0;
        issue_valid = 1'b1;
        #1;
        n_checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_busy: busy_a=%b busy_b=%b required 1/0", busy_a, busy_b);
        end
        tick();
        issue_valid = 1'b0;
        #1;
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_set_wins: we=%b addr=%0d busy_a=%b required 1/9/1", rf_we, rf_waddr, busy_a);
        end
        lat_valid = 1'b1;
        lat_data = 32'h9A;
        tick();
        lat_valid = 1'b0;
        tick();
        n_checks++;
        if (rf_we !== 1'b1 || rf_wdata !== 32'h9A || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_clear: we=%b data=%h busy_a=%b required 1/9a/0", rf_we, rf_wdata, busy_a);
        end
    endtask

    task automatic test_zero();
        lat_valid = 1'b1;
        lat_rd = 5'd0;
        lat_data = 32'h5;
        issue_valid = 1'b1;
        issue_rd = 5'd0;
        query_a = 5'd0;
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (rf_we !== 1'b0 || busy_a !== 1'b0 || lat_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_reg: we=%b busy_a=%b ready=%b required 0/0/1", rf_we, busy_a, lat_ready);
        end
        lat_valid = 1'b1;
        lat_rd = 5'd12;
        lat_data = 32'h77;
        tick();
        lat_valid = 1'b0;
        tick();
        n_checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h77) begin
            n_fail++;
            $display("FAIL zero_popped: we=%b addr=%0d data=%h required 1/12/77", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1;
        alu_rd = 5'd6;
        lat_valid = 1'b1;
        issue_valid = 1'b1;
        query_a = 5'd2;
        query_b = 5'd4;
        for (int k = 0; k < 3; k++) begin
            lat_rd = 5'(2 + 2 * (k % 2));
            lat_data = k;
            issue_rd = 5'(2 + 2 * (k % 2));
            tick();
        end
        idle_inputs();
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        n_checks++;
        if (rf_we !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: we=%b busy=%b%b required 0/00", rf_we, busy_a, busy_b);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (rf_we !== 1'b0 || lat_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_after%0d: we=%b ready=%b required 0/1", k, rf_we, lat_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            alu_valid = ($urandom_range(0, 9) < 4);
            alu_rd = 5'($urandom_range(0, 31));
            alu_data = $urandom;
            lat_valid = ($urandom_range(0, 1) == 1);
            lat_rd = 5'($urandom_range(0, 7));
            lat_data = $urandom;
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd = 5'($urandom_range(0, 7));
            query_a = 5'($urandom_range(0, 7));
            query_b = 5'($urandom_range(0, 7));
            #1;
            n_checks++;
            if (lat_ready !== (m_q.size() != DEPTH) || busy_a !== (m_pend[query_a] && query_a != 0)
                || busy_b !== (m_pend[query_b] && query_b != 0)) begin
                n_fail++;
                $display("FAIL rand_comb%0d: ready=%b busy=%b%b required %b/%b%b", c, lat_ready, busy_a, busy_b,
                         m_q.size() != DEPTH, m_pend[query_a] && query_a != 0, m_pend[query_b] && query_b != 0);
            end
            tick();
            n_checks++;
            if (rf_we !== m_we || (m_we && (rf_waddr !== m_addr || rf_wdata !== m_data))) begin
                n_fail++;
                $display("FAIL rand_rf%0d: we=%b addr=%0d data=%h required %b/%0d/%h", c, rf_we, rf_waddr, rf_wdata, m_we, m_addr, m_data);
            end
`ifdef WB_FWD_EN
            n_checks++;
            if (fwd_a_valid !== (m_we && m_addr == query_a && query_a != 0)
                || fwd_b_valid !== (m_we && m_addr == query_b && query_b != 0)
                || (fwd_a_valid && fwd_a_data !== m_data) || (fwd_b_valid && fwd_b_data !== m_data)) begin
                n_fail++;
                $display("FAIL rand_fwd%0d: a=%b/%h b=%b/%h data required %h", c, fwd_a_valid, fwd_a_data, fwd_b_valid, fwd_b_data, m_data);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_priority();
        test_fill();
        test_scoreboard();
        test_zero();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
